// File: rtl/prefetch_buffer.sv
// prefetch_buffer: fetches instruction words ahead of if_stage and buffers them with their addresses.
// Define PREFETCH_BYPASS_EN to forward a response straight to if_stage when the buffer is empty.
module prefetch_buffer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_enable_i,
  input  logic [31:0] boot_addr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        fetch_valid_o,
  input  logic        fetch_ready_i,
  output logic [31:0] fetch_rdata_o,
  output logic [31:0] fetch_addr_o,
  output logic        busy_o,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  output logic [31:0] instr_addr_o,
  input  logic [31:0] instr_rdata_i
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [31:0] data_q [FIFO_DEPTH];
  logic [31:0] addr_q [FIFO_DEPTH];
  logic [31:0] aq [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, aq_rd, aq_wr;
  logic [CW-1:0] count, outstanding, discard, out_next;
  logic [31:0] fetch_ptr, shadow;
  logic shadow_v, pend, gnt, rv, drop, push, pop, redir, hold, byp;
  always_comb begin
    instr_req_o = (state == RUN) &&
                  (((CW+1)'(count) + (CW+1)'(outstanding) < (CW+1)'(FIFO_DEPTH)) || pend);
    instr_addr_o = fetch_ptr;
    busy_o = (outstanding != '0) || pend;
    gnt = instr_req_o && instr_gnt_i;
    rv = instr_rvalid_i && (outstanding != '0);
    drop = discard != '0;
    redir = redirect_i && (state == RUN);
    hold = instr_req_o && !instr_gnt_i;
    out_next = outstanding + CW'(gnt) - CW'(rv);
`ifdef PREFETCH_BYPASS_EN
    byp = rv && !drop && (count == '0);
    fetch_valid_o = (count != '0) || byp;
    fetch_rdata_o = (count != '0) ? data_q[rd_ptr] : byp ? instr_rdata_i : '0;
    fetch_addr_o = (count != '0) ? addr_q[rd_ptr] : byp ? aq[aq_rd] : '0;
`else
    byp = 1'b0;
    fetch_valid_o = count != '0;
    fetch_rdata_o = fetch_valid_o ? data_q[rd_ptr] : '0;
    fetch_addr_o = fetch_valid_o ? addr_q[rd_ptr] : '0;
`endif
    push = rv && !drop && !(byp && fetch_ready_i) && !redir;
    pop = (count != '0) && fetch_ready_i;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      aq_rd <= '0;
      aq_wr <= '0;
      count <= '0;
      outstanding <= '0;
      discard <= '0;
      fetch_ptr <= '0;
      shadow <= '0;
      shadow_v <= 1'b0;
      pend <= 1'b0;
    end else if (state == IDLE) begin
      if (fetch_enable_i) begin
        state <= RUN;
        fetch_ptr <= boot_addr_i & ~32'h3;
      end
    end else begin
      pend <= hold;
      outstanding <= out_next;
      if (gnt) aq_wr <= aq_wr + AW'(1);
      if (rv) aq_rd <= aq_rd + AW'(1);
      if (redir) begin
        count <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        discard <= out_next + CW'(hold);
      end else begin
        count <= count + CW'(push) - CW'(pop);
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        if (rv && drop) discard <= discard - CW'(1);
      end
      // an ungranted request must keep its address, so the redirect waits in the shadow
      if (redir && !hold) begin
        fetch_ptr <= redirect_addr_i & ~32'h3;
        shadow_v <= 1'b0;
      end else if (gnt) begin
        fetch_ptr <= shadow_v ? shadow : fetch_ptr + 32'd4;
        shadow_v <= 1'b0;
      end
      if (redir && hold) begin
        shadow <= redirect_addr_i & ~32'h3;
        shadow_v <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_q[wr_ptr] <= instr_rdata_i;
      addr_q[wr_ptr] <= aq[aq_rd];
    end
    if (gnt) aq[aq_wr] <= fetch_ptr;
  end
endmodule

// File: tb/tb_prefetch_buffer.sv
// tb_prefetch_buffer: directed checks of prefetch_buffer against a fixed-latency memory model.
module tb_prefetch_buffer;
  logic clk = 1'b0, rst_ni = 1'b0, fetch_enable_i = 1'b0, redirect_i = 1'b0, fetch_ready_i = 1'b0;
  logic [31:0] boot_addr_i = '0, redirect_addr_i = '0;
  logic fetch_valid_o, busy_o, instr_req_o, instr_gnt_i, instr_rvalid_i, gnt_en = 1'b0;
  logic [31:0] fetch_rdata_o, fetch_addr_o, instr_addr_o, instr_rdata_i;
  logic [3:0] rv_pipe = '0;
  logic [31:0] a_pipe [4];
  int checks = 0, failures = 0, lat = 1;
  always #5 clk = ~clk;
  prefetch_buffer #(.FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .fetch_enable_i(fetch_enable_i), .boot_addr_i(boot_addr_i),
    .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i), .fetch_valid_o(fetch_valid_o),
    .fetch_ready_i(fetch_ready_i), .fetch_rdata_o(fetch_rdata_o), .fetch_addr_o(fetch_addr_o),
    .busy_o(busy_o), .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_addr_o(instr_addr_o), .instr_rdata_i(instr_rdata_i)
  );
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction
  assign instr_gnt_i = instr_req_o & gnt_en;
  assign instr_rvalid_i = rv_pipe[lat-1];
  assign instr_rdata_i = mem(a_pipe[lat-1]);
  always @(posedge clk) begin
    rv_pipe <= {rv_pipe[2:0], instr_gnt_i};
    a_pipe[0] <= instr_addr_o;
    for (int i = 1; i < 4; i++) a_pipe[i] <= a_pipe[i-1];
  end
  task automatic start(input logic [31:0] boot, input logic rdy, input logic ge, input int l);
    rst_ni = 1'b0; fetch_enable_i = 1'b0; redirect_i = 1'b0; fetch_ready_i = rdy; gnt_en = ge; lat = l;
    @(negedge clk); @(negedge clk); rst_ni = 1'b1; @(negedge clk);
    boot_addr_i = boot; fetch_enable_i = 1'b1;
    @(negedge clk); fetch_enable_i = 1'b0;
  endtask
  task automatic test_reset;
    logic bad;
    @(negedge clk);
    checks++; if (instr_req_o !== 1'b0 || instr_addr_o !== 32'h0) begin failures++; $display("FAIL reset_bus got req=%b addr=%h exp req=0 addr=0", instr_req_o, instr_addr_o); end
    checks++; if (fetch_valid_o !== 1'b0 || fetch_rdata_o !== 32'h0 || fetch_addr_o !== 32'h0) begin failures++; $display("FAIL reset_fetch got v=%b d=%h a=%h exp all 0", fetch_valid_o, fetch_rdata_o, fetch_addr_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    rst_ni = 1'b1; redirect_i = 1'b1; redirect_addr_i = 32'h400; gnt_en = 1'b1; bad = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (instr_req_o !== 1'b0) bad = 1'b1;
    end
    redirect_i = 1'b0;
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL idle_redirect got req during IDLE exp none"); end
  endtask
  task automatic test_boot;
    int nreq = 0, nf = 0, first = -1, exp_lat;
`ifdef PREFETCH_BYPASS_EN
    exp_lat = 1;
`else
    exp_lat = 2;
`endif
    start(32'h80, 1'b1, 1'b1, 1);
    for (int c = 0; c < 12; c++) begin
      if (instr_req_o && instr_gnt_i && nreq < 4) begin
        checks++; if (instr_addr_o !== 32'h80 + 4*nreq) begin failures++; $display("FAIL boot_req got=%h exp=%h", instr_addr_o, 32'h80 + 4*nreq); end
        nreq++;
      end
      if (fetch_valid_o && nf < 4) begin
        if (first < 0) first = c;
        checks++; if (fetch_addr_o !== 32'h80 + 4*nf || fetch_rdata_o !== mem(32'h80 + 4*nf)) begin failures++; $display("FAIL boot_fetch got a=%h d=%h exp a=%h d=%h", fetch_addr_o, fetch_rdata_o, 32'h80 + 4*nf, mem(32'h80 + 4*nf)); end
        nf++;
      end
      @(negedge clk);
    end
    checks++; if (first != exp_lat || nf != 4) begin failures++; $display("FAIL boot_latency got first=%0d n=%0d exp first=%0d n=4", first, nf, exp_lat); end
  endtask
  task automatic test_backpressure;
    int g = 0, found = 0;
    logic [31:0] a = '0;
    start(32'h80, 1'b0, 1'b1, 1);
    for (int c = 0; c < 10; c++) begin
      if (instr_req_o && instr_gnt_i) g++;
      @(negedge clk);
    end
    checks++; if (g != 4 || instr_req_o !== 1'b0) begin failures++; $display("FAIL bp_grants got g=%0d req=%b exp g=4 req=0", g, instr_req_o); end
    checks++; if (fetch_valid_o !== 1'b1 || fetch_addr_o !== 32'h80) begin failures++; $display("FAIL bp_head got v=%b a=%h exp v=1 a=00000080", fetch_valid_o, fetch_addr_o); end
    fetch_ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (instr_req_o) begin a = instr_addr_o; found = 1; break; end
      @(negedge clk);
    end
    checks++; if (found != 1 || a !== 32'h90) begin failures++; $display("FAIL bp_resume got found=%0d a=%h exp a=00000090", found, a); end
  endtask
  task automatic test_redirect_outstanding;
    logic seen = 1'b0, bad = 1'b0;
    start(32'h80, 1'b1, 1'b1, 2);
    @(negedge clk);
    checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h84 || busy_o !== 1'b1) begin failures++; $display("FAIL redir_pre got req=%b a=%h busy=%b exp 1 00000084 1", instr_req_o, instr_addr_o, busy_o); end
    redirect_i = 1'b1; redirect_addr_i = 32'h203;
    @(negedge clk); redirect_i = 1'b0;
    checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h200) begin failures++; $display("FAIL redir_req got req=%b a=%h exp 1 00000200", instr_req_o, instr_addr_o); end
    for (int c = 0; c < 8; c++) begin
      if (fetch_valid_o && !seen) begin
        seen = 1'b1;
        if (fetch_addr_o !== 32'h200 || fetch_rdata_o !== mem(32'h200)) bad = 1'b1;
      end
      @(negedge clk);
    end
    checks++; if (!seen || bad) begin failures++; $display("FAIL redir_first got seen=%b bad=%b exp first fetch 00000200", seen, bad); end
  endtask
  task automatic test_redirect_pending;
    logic stable = 1'b1, seen = 1'b0, bad = 1'b0;
    start(32'h80, 1'b1, 1'b0, 1);
    redirect_i = 1'b1; redirect_addr_i = 32'h1F0;
    @(negedge clk); redirect_addr_i = 32'h200;
    if (instr_addr_o !== 32'h80 || instr_req_o !== 1'b1) stable = 1'b0;
    @(negedge clk); redirect_i = 1'b0;
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL pend_busy got=%b exp=1", busy_o); end
    if (instr_addr_o !== 32'h80 || instr_req_o !== 1'b1) stable = 1'b0;
    @(negedge clk);
    if (instr_addr_o !== 32'h80 || instr_req_o !== 1'b1) stable = 1'b0;
    checks++; if (!stable) begin failures++; $display("FAIL pend_hold got a=%h exp 00000080 held with req", instr_addr_o); end
    gnt_en = 1'b1;
    @(negedge clk);
    checks++; if (instr_addr_o !== 32'h200) begin failures++; $display("FAIL pend_next got=%h exp=00000200", instr_addr_o); end
    for (int c = 0; c < 6; c++) begin
      if (fetch_valid_o && !seen) begin
        seen = 1'b1;
        if (fetch_addr_o !== 32'h200 || fetch_rdata_o !== mem(32'h200)) bad = 1'b1;
      end
      @(negedge clk);
    end
    checks++; if (!seen || bad) begin failures++; $display("FAIL pend_first got seen=%b bad=%b exp first fetch 00000200", seen, bad); end
  endtask
  task automatic test_wrap;
    int nf = 0;
    logic [31:0] exp_a [2];
    exp_a[0] = 32'hFFFF_FFFC; exp_a[1] = 32'h0;
    start(32'h80, 1'b1, 1'b1, 1);
    redirect_i = 1'b1; redirect_addr_i = 32'hFFFF_FFFC;
    @(negedge clk); redirect_i = 1'b0;
    checks++; if (instr_addr_o !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_req0 got=%h exp=fffffffc", instr_addr_o); end
    @(negedge clk);
    checks++; if (instr_addr_o !== 32'h0) begin failures++; $display("FAIL wrap_req1 got=%h exp=00000000", instr_addr_o); end
    for (int c = 0; c < 6; c++) begin
      if (fetch_valid_o && nf < 2) begin
        checks++; if (fetch_addr_o !== exp_a[nf] || fetch_rdata_o !== mem(exp_a[nf])) begin failures++; $display("FAIL wrap_fetch got a=%h d=%h exp a=%h", fetch_addr_o, fetch_rdata_o, exp_a[nf]); end
        nf++;
      end
      @(negedge clk);
    end
    checks++; if (nf != 2) begin failures++; $display("FAIL wrap_count got=%0d exp=2", nf); end
  endtask
  task automatic test_enable_ignored;
    start(32'h80, 1'b1, 1'b1, 1);
    @(negedge clk); @(negedge clk);
    boot_addr_i = 32'h1000; fetch_enable_i = 1'b1;
    @(negedge clk); @(negedge clk); fetch_enable_i = 1'b0;
    checks++; if (instr_addr_o !== 32'h90) begin failures++; $display("FAIL enable_run got=%h exp=00000090", instr_addr_o); end
  endtask
  task automatic test_async_reset;
    logic bad = 1'b0, seen = 1'b0;
    start(32'h80, 1'b1, 1'b1, 2);
    @(negedge clk); @(negedge clk);
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL ar_busy_pre got=%b exp=1", busy_o); end
    rst_ni = 1'b0; #1;
    checks++; if ({instr_req_o, instr_addr_o, fetch_valid_o, fetch_rdata_o, fetch_addr_o, busy_o} !== '0) begin failures++; $display("FAIL ar_outputs got req=%b a=%h v=%b busy=%b exp all 0", instr_req_o, instr_addr_o, fetch_valid_o, busy_o); end
    @(negedge clk); @(negedge clk); rst_ni = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (instr_req_o !== 1'b0 || fetch_valid_o !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL ar_idle got activity after reset exp IDLE"); end
    boot_addr_i = 32'h43; fetch_enable_i = 1'b1;
    @(negedge clk); fetch_enable_i = 1'b0;
    checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h40) begin failures++; $display("FAIL ar_reboot got req=%b a=%h exp 1 00000040", instr_req_o, instr_addr_o); end
    for (int c = 0; c < 6; c++) begin
      if (fetch_valid_o && !seen) begin
        seen = 1'b1;
        checks++; if (fetch_addr_o !== 32'h40 || fetch_rdata_o !== mem(32'h40)) begin failures++; $display("FAIL ar_fetch got a=%h d=%h exp a=00000040", fetch_addr_o, fetch_rdata_o); end
      end
      @(negedge clk);
    end
    checks++; if (!seen) begin failures++; $display("FAIL ar_fetch_seen got none exp one"); end
  endtask
  initial begin
    test_reset;
    test_boot;
    test_backpressure;
    test_redirect_outstanding;
    test_redirect_pending;
    test_wrap;
    test_enable_ignored;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
